// File: rtl/aes_mc_pkg.sv
// Shared GF(2^8) helpers and types for the MixColumns datapath.
package aes_mc_pkg;

  localparam logic [7:0] AES_POLY = 8'h1B;

  typedef enum logic {
    MC_FWD = 1'b0,
    MC_INV = 1'b1
  } mc_mode_e;

  // Element 0 is the most significant byte (a0).
  typedef logic [0:3][7:0] aes_col_t;

  // Per byte: a, 2a, 4a, 8a -- every coefficient is an XOR of these.
  typedef struct packed {
    aes_col_t x0;
    aes_col_t x1;
    aes_col_t x2;
    aes_col_t x3;
  } mc_prod_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_2(input logic [7:0] a);
    return xtime(a);
  endfunction

  function automatic logic [7:0] gf_mul_3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul_9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul_11(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul_13(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul_14(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
  endfunction

endpackage

// File: rtl/aes_mixcol_col.sv
// One-column MixColumns/InvMixColumns, split into an xtime product half and
// an XOR combine half so the parent can register between them.
module aes_mixcol_col
  import aes_mc_pkg::*;
(
  input  aes_col_t col_in,
  output mc_prod_t prod,
  input  mc_prod_t prod_in,
  input  mc_mode_e mode,
  output aes_col_t col_out
);

  always_comb begin
    logic [7:0] t1, t2;
    prod = '0;
    for (int i = 0; i < 4; i++) begin
      t1 = xtime(col_in[i]);
      t2 = xtime(t1);
      prod.x0[i] = col_in[i];
      prod.x1[i] = t1;
      prod.x2[i] = t2;
      prod.x3[i] = xtime(t2);
    end
  end

  // Row i uses coefficient k on byte (i+k) mod 4.
  always_comb begin
    logic [1:0] j1, j2, j3;
    logic [7:0] m0, m1, m2, m3;
    col_out = '0;
    for (int i = 0; i < 4; i++) begin
      j1 = 2'(i + 1);
      j2 = 2'(i + 2);
      j3 = 2'(i + 3);
      if (mode == MC_INV) begin
        m0 = prod_in.x3[i]  ^ prod_in.x2[i]  ^ prod_in.x1[i];
        m1 = prod_in.x3[j1] ^ prod_in.x1[j1] ^ prod_in.x0[j1];
        m2 = prod_in.x3[j2] ^ prod_in.x2[j2] ^ prod_in.x0[j2];
        m3 = prod_in.x3[j3] ^ prod_in.x0[j3];
      end else begin
        m0 = prod_in.x1[i];
        m1 = prod_in.x1[j1] ^ prod_in.x0[j1];
        m2 = prod_in.x0[j2];
        m3 = prod_in.x0[j3];
      end
      col_out[i] = m0 ^ m1 ^ m2 ^ m3;
    end
  end

endmodule

// File: rtl/aes_mixcol_pipe.sv
// Pipelined MixColumns/InvMixColumns over NUM_COL columns with valid/ready
// flow control; REG_MID adds a register after the xtime product stage.
module aes_mixcol_pipe
  import aes_mc_pkg::*;
#(
  parameter int NUM_COL = 4,
  parameter int TAG_W   = 4,
  parameter int REG_MID = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_inv,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [32*NUM_COL-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TAG_W-1:0]       out_tag,
  output logic [32*NUM_COL-1:0]  out_data
);

  mc_prod_t [NUM_COL-1:0] prod_d;
  mc_prod_t [NUM_COL-1:0] prod_c;
  aes_col_t [NUM_COL-1:0] res;
  mc_mode_e               mode_c;
  logic                   mid_valid;
  logic [TAG_W-1:0]       mid_tag;
  logic                   out_load;

  assign out_load = !out_valid || out_ready;

  for (genvar c = 0; c < NUM_COL; c++) begin : g_col
    aes_mixcol_col u_col (
      .col_in  (in_data[32*c +: 32]),
      .prod    (prod_d[c]),
      .prod_in (prod_c[c]),
      .mode    (mode_c),
      .col_out (res[c])
    );
  end

  if (REG_MID != 0) begin : g_mid
    logic                   s1_valid;
    mc_prod_t [NUM_COL-1:0] s1_prod;
    mc_mode_e               s1_mode;
    logic [TAG_W-1:0]       s1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1_prod  <= '0;
        s1_mode  <= MC_FWD;
        s1_tag   <= '0;
      end else if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_prod <= prod_d;
          s1_mode <= mc_mode_e'(in_inv);
          s1_tag  <= in_tag;
        end
      end
    end

    assign in_ready  = !s1_valid || out_load;
    assign prod_c    = s1_prod;
    assign mode_c    = s1_mode;
    assign mid_valid = s1_valid;
    assign mid_tag   = s1_tag;
  end else begin : g_flat
    assign in_ready  = out_load;
    assign prod_c    = prod_d;
    assign mode_c    = mc_mode_e'(in_inv);
    assign mid_valid = in_valid;
    assign mid_tag   = in_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (out_load) begin
      out_valid <= mid_valid;
      if (mid_valid) begin
        out_data <= res;
        out_tag  <= mid_tag;
      end
    end
  end

endmodule

// File: tb/tb_aes_mixcol_pipe.sv
// Bench for aes_mixcol_pipe: REG_MID=0 (index 0) and REG_MID=1 (index 1)
// instances, NUM_COL=4, checked against a GF(2^8) matrix reference model.
module tb_aes_mixcol_pipe;

  localparam int NC = 4;
  localparam int TW = 4;
  localparam int DW = 32 * NC;

  localparam logic [DW-1:0] F_IN  = {32'hdb135345, 32'hf20a225c, 32'hc6c6c6c6, 32'h01010101};
  localparam logic [DW-1:0] F_OUT = {32'h8e4da1bc, 32'h9fdc589d, 32'hc6c6c6c6, 32'h01010101};

  typedef struct {
    logic [DW-1:0] d;
    logic          inv;
    logic [TW-1:0] tag;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid [2];
  logic          in_ready [2];
  logic          in_inv   [2];
  logic [TW-1:0] in_tag   [2];
  logic [DW-1:0] in_data  [2];
  logic          out_valid[2];
  logic          out_ready[2];
  logic [TW-1:0] out_tag  [2];
  logic [DW-1:0] out_data [2];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes_mixcol_pipe #(.NUM_COL(NC), .TAG_W(TW), .REG_MID(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_inv(in_inv[0]),
    .in_tag(in_tag[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_tag(out_tag[0]), .out_data(out_data[0])
  );

  aes_mixcol_pipe #(.NUM_COL(NC), .TAG_W(TW), .REG_MID(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_inv(in_inv[1]),
    .in_tag(in_tag[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_tag(out_tag[1]), .out_data(out_data[1])
  );

  // Carry-less product then reduction by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    int         cf[4];
    logic [7:0] a[4];
    logic [7:0] b[4];
    if (inv) cf = '{14, 11, 13, 9};
    else     cf = '{2, 3, 1, 1};
    for (int i = 0; i < 4; i++) a[i] = col[31-8*i -: 8];
    for (int i = 0; i < 4; i++) begin
      b[i] = 8'h00;
      for (int j = 0; j < 4; j++) b[i] = b[i] ^ gmul(a[j], 8'(cf[(j - i + 4) % 4]));
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [DW-1:0] mix_beat(input logic [DW-1:0] d, input logic inv);
    logic [DW-1:0] r;
    for (int c = 0; c < NC; c++) r[32*c +: 32] = mix_col(d[32*c +: 32], inv);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if (out_valid[k] !== 1'b0) begin
        n_err++; $display("FAIL reset_out_valid[%0d] got %b want 0", k, out_valid[k]);
      end
      n_vec++;
      if (out_data[k] !== '0) begin
        n_err++; $display("FAIL reset_out_data[%0d] got %h want 0", k, out_data[k]);
      end
      n_vec++;
      if (out_tag[k] !== '0) begin
        n_err++; $display("FAIL reset_out_tag[%0d] got %h want 0", k, out_tag[k]);
      end
      n_vec++;
      if (in_ready[k] !== 1'b1) begin
        n_err++; $display("FAIL reset_in_ready[%0d] got %b want 1", k, in_ready[k]);
      end
    end
  endtask

  // Known vectors, alternating forward/inverse beats with no gap.
  task automatic test_alt_mode(input int k);
    int            lat;
    logic          iv;
    logic [DW-1:0] want;
    lat = (k == 0) ? 1 : 2;
    out_ready[k] = 1'b1;
    for (int cyc = 0; cyc < 8 + lat + 2; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 8) begin
        iv = cyc[0];
        in_valid[k] = 1'b1;
        in_inv[k]   = iv;
        in_data[k]  = iv ? F_OUT : F_IN;
        in_tag[k]   = TW'(cyc + 3);
      end else begin
        in_valid[k] = 1'b0;
      end
      @(negedge clk);
      n_vec++;
      if (out_valid[k] !== ((cyc >= lat) && (cyc < 8 + lat))) begin
        n_err++; $display("FAIL alt_valid[%0d] cyc %0d got %b", k, cyc, out_valid[k]);
      end
      if (cyc >= lat && cyc < 8 + lat) begin
        want = ((cyc - lat) % 2 == 1) ? F_IN : F_OUT;
        n_vec++;
        if (out_data[k] !== want) begin
          n_err++; $display("FAIL alt_data[%0d] cyc %0d got %h want %h", k, cyc, out_data[k], want);
        end
      end
    end
  endtask

  task automatic test_throughput(input int k);
    int            lat;
    logic [DW-1:0] d[16];
    logic          iv[16];
    logic [DW-1:0] want;
    lat = (k == 0) ? 1 : 2;
    for (int i = 0; i < 16; i++) begin
      d[i]  = rand_data();
      iv[i] = 1'($urandom_range(1));
    end
    out_ready[k] = 1'b1;
    for (int cyc = 0; cyc < 16 + lat + 2; cyc++) begin
      @(posedge clk); #1;
      if (cyc < 16) begin
        in_valid[k] = 1'b1;
        in_data[k]  = d[cyc];
        in_inv[k]   = iv[cyc];
        in_tag[k]   = TW'(cyc);
      end else begin
        in_valid[k] = 1'b0;
      end
      @(negedge clk);
      if (cyc < 16) begin
        n_vec++;
        if (in_ready[k] !== 1'b1) begin
          n_err++; $display("FAIL thru_in_ready[%0d] cyc %0d got %b want 1", k, cyc, in_ready[k]);
        end
      end
      n_vec++;
      if (out_valid[k] !== ((cyc >= lat) && (cyc < 16 + lat))) begin
        n_err++; $display("FAIL thru_valid[%0d] cyc %0d got %b", k, cyc, out_valid[k]);
      end
      if (cyc >= lat && cyc < 16 + lat) begin
        want = mix_beat(d[cyc-lat], iv[cyc-lat]);
        n_vec++;
        if (out_tag[k] !== TW'(cyc - lat)) begin
          n_err++; $display("FAIL thru_tag[%0d] cyc %0d got %0d want %0d", k, cyc, out_tag[k], cyc - lat);
        end
        n_vec++;
        if (out_data[k] !== want) begin
          n_err++; $display("FAIL thru_data[%0d] cyc %0d got %h want %h", k, cyc, out_data[k], want);
        end
      end
    end
  endtask

  // Queue-scoreboarded stream; ready is dropped over [stall_lo, stall_hi).
  task automatic test_stream(input int k, input int nb, input int pv, input int pr,
                             input int stall_lo, input int stall_hi);
    beat_t         q[$];
    beat_t         b, e;
    int            sent, got, cyc;
    logic          acc, stall;
    logic [DW-1:0] hold_d;
    logic [TW-1:0] hold_t;
    sent = 0; got = 0; cyc = 0; acc = 1'b0; stall = 1'b0;
    hold_d = '0; hold_t = '0;
    b.d = '0; b.inv = 1'b0; b.tag = '0;
    in_valid[k] = 1'b0;
    while (got < nb && cyc < nb * 20 + 100) begin
      @(posedge clk); #1;
      if (!in_valid[k] || acc) begin
        if (sent < nb && $urandom_range(99) < pv) begin
          b.d = rand_data(); b.inv = 1'($urandom_range(1)); b.tag = TW'($urandom);
          in_valid[k] = 1'b1; in_data[k] = b.d; in_inv[k] = b.inv; in_tag[k] = b.tag;
        end else begin
          in_valid[k] = 1'b0; in_data[k] = rand_data(); in_inv[k] = 1'($urandom_range(1));
        end
      end
      out_ready[k] = (cyc >= stall_lo && cyc < stall_hi) ? 1'b0 : ($urandom_range(99) < pr);
      @(negedge clk);
      acc = in_valid[k] && in_ready[k];
      if (acc) begin
        q.push_back(b); sent++;
      end
      if (cyc == stall_hi - 1) begin
        n_vec++;
        if (in_ready[k] !== 1'b0) begin
          n_err++; $display("FAIL stall_full_in_ready[%0d] got %b want 0", k, in_ready[k]);
        end
      end
      if (cyc == stall_hi) begin
        n_vec++;
        if (in_ready[k] !== 1'b1) begin
          n_err++; $display("FAIL stall_release_in_ready[%0d] got %b want 1", k, in_ready[k]);
        end
      end
      if (stall) begin
        n_vec++;
        if (out_valid[k] !== 1'b1 || out_data[k] !== hold_d || out_tag[k] !== hold_t) begin
          n_err++;
          $display("FAIL stall_hold[%0d] cyc %0d got v=%b %h/%h want v=1 %h/%h",
                   k, cyc, out_valid[k], out_data[k], out_tag[k], hold_d, hold_t);
        end
      end
      if (out_valid[k] && out_ready[k]) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL stream_extra[%0d] got %h want no beat", k, out_data[k]);
        end else begin
          e = q.pop_front(); got++;
          if (out_data[k] !== mix_beat(e.d, e.inv) || out_tag[k] !== e.tag) begin
            n_err++;
            $display("FAIL stream_data[%0d] beat %0d got %h/%h want %h/%h",
                     k, got, out_data[k], out_tag[k], mix_beat(e.d, e.inv), e.tag);
          end
          n_vec++;
          if (mix_beat(out_data[k], !e.inv) !== e.d) begin
            n_err++; $display("FAIL stream_roundtrip[%0d] beat %0d got %h want %h",
                              k, got, mix_beat(out_data[k], !e.inv), e.d);
          end
        end
      end
      stall  = out_valid[k] && !out_ready[k];
      hold_d = out_data[k];
      hold_t = out_tag[k];
      cyc++;
    end
    n_vec++;
    if (got != nb) begin
      n_err++; $display("FAIL stream_count[%0d] got %0d want %0d", k, got, nb);
    end
    in_valid[k]  = 1'b0;
    out_ready[k] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_vec++;
      if (out_valid[k] !== 1'b0) begin
        n_err++; $display("FAIL stream_drain[%0d] got out_valid %b want 0", k, out_valid[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    test_stream(1, 12, 100, 100, 4, 9);
  endtask

  task automatic test_random(input int k);
    test_stream(k, 150, 70, 70, -1, -1);
  endtask

  task automatic test_reset_midstream();
    out_ready[1] = 1'b1;
    @(posedge clk); #1;
    in_valid[1] = 1'b1; in_inv[1] = 1'b0; in_data[1] = rand_data(); in_tag[1] = 4'd1;
    @(posedge clk); #1;
    in_data[1] = rand_data(); in_tag[1] = 4'd2;
    @(posedge clk); #1;
    in_valid[1] = 1'b0;
    #2;
    n_vec++;
    if (out_valid[1] !== 1'b1) begin
      n_err++; $display("FAIL rstmid_inflight got out_valid %b want 1", out_valid[1]);
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid[1] !== 1'b0 || out_data[1] !== '0 || out_tag[1] !== '0) begin
      n_err++; $display("FAIL rstmid_async got v=%b d=%h t=%h want 0/0/0",
                        out_valid[1], out_data[1], out_tag[1]);
    end
    @(negedge clk); #2;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_vec++;
      if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
        n_err++; $display("FAIL rstmid_after got v=%b rdy=%b want v=0 rdy=1",
                          out_valid[1], in_ready[1]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; in_inv[k] = 1'b0; in_tag[k] = '0;
      in_data[k] = '0; out_ready[k] = 1'b1;
    end
    #22 rst_n = 1'b1;
    test_reset();
    test_alt_mode(1);
    test_alt_mode(0);
    test_throughput(1);
    test_throughput(0);
    test_backpressure();
    test_reset_midstream();
    test_random(0);
    test_random(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_mixcol_pipe.md
Name: aes_mixcol_pipe

Overview:
- Parametrised, pipelined AES MixColumns / InvMixColumns datapath slice for the AES round logic.
- Processes NUM_COL 32-bit state columns per beat. Mode (forward/inverse) and a sideband tag are selected per transaction.
- Valid/ready handshake on both sides; full throughput of one beat per cycle under no backpressure.
- Sits between SubBytes/ShiftRows output and AddRoundKey input.

Parameters:
- NUM_COL, 4, columns per beat; data width DW = 32*NUM_COL (legal 1..4).
- TAG_W, 4, width of sideband tag carried alongside data (legal >= 1).
- REG_MID, 1, 1 = intermediate register after the GF product stage (latency 2); 0 = single stage (latency 1).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept input this cycle
- in_inv  in  1  0 = MixColumns, 1 = InvMixColumns
- in_tag  in  TAG_W  sideband, passed through unchanged
- in_data  in  DW  column c occupies bits [32c+31:32c]; within a column a0 = [31:24], a3 = [7:0]
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_tag  out  TAG_W  tag of the output beat
- out_data  out  DW  transformed columns, same layout as in_data

Behaviour:
- Reset: asynchronous on rst_n low. All stage valid flags = 0, all data/tag/mode registers = 0; out_valid = 0, out_data = 0, out_tag = 0. in_ready = 1 from the first cycle after rst_n deasserts.
- Forward mode, per column, all arithmetic in GF(2^8) mod x^8+x^4+x^3+x+1: b0 = 2a0^3a1^a2^a3, b1 = a0^2a1^3a2^a3, b2 = a0^a1^2a2^3a3, b3 = 3a0^a1^a2^2a3.
- Inverse mode uses the same structure with coefficients (14,11,13,9) in place of (2,3,1,1), rotated identically.
- xtime(a) = (a<<1) ^ (a[7] ? 8'h1B : 8'h00). Every product is built from xtime chains only: no lookup tables, no multipliers.
- Pipeline with REG_MID = 1:
  - Stage 1 registers xtime1/2/3 of every input byte, plus mode and tag.
  - Stage 2 registers the final XOR combination.
- Pipeline with REG_MID = 0: the whole function is computed combinationally into the single output register.
- Latency: a beat accepted on cycle t appears on out_valid at cycle t+1+REG_MID when out_ready = 1.
- Handshake:
  - Transfer on valid & ready at the rising edge.
  - A stage register loads when its valid is 0 or the next stage/consumer accepts this cycle.
  - in_ready = stage-1 load condition; a combinational path from out_ready to in_ready is permitted.
  - out_valid must not drop while out_ready = 0.
  - out_data and out_tag must be stable while out_valid = 1 and out_ready = 0.
- No bubbles: with out_ready held at 1, a continuous in_valid stream yields a continuous out_valid stream.
- Full pipeline with out_ready = 0: in_ready = 0 and all registers hold. When out_ready rises, one beat drains per cycle and in_ready reasserts in the same cycle.
- Mode changes between consecutive beats are legal. Each beat uses its own captured in_inv; there is no flush penalty.
- in_data and in_inv are ignored when in_valid = 0. Data registers may load don't-care values only while their valid is 0.
- Reset asserted mid-stream: in-flight beats are discarded, with no partial output after release.

Decomposition:
- Package aes_mc_pkg holds:
  - constant AES_POLY = 8'h1B
  - functions xtime and gf_mul_{2,3,9,11,13,14}
  - typedef mc_mode_e {MC_FWD, MC_INV}
  - typedef aes_col_t as a 4-element array of 8-bit bytes
- Sub-module aes_mixcol_col: combinational, one column plus mode, split into product and combine halves so REG_MID can cut between them. aes_mixcol_pipe instantiates NUM_COL copies and owns the handshake and registers.

Test Plan:
- Forward, NUM_COL=1: column 32'hdb135345 -> 32'h8e4da1bc; 32'hf20a225c -> 32'h9fdc589d; 32'hc6c6c6c6 -> 32'hc6c6c6c6.
- Inverse: 32'h8e4da1bc -> 32'hdb135345; 32'h9fdc589d -> 32'hf20a225c. Back-to-back alternating in_inv beats each give the correct result with no bubble.
- Throughput, REG_MID=1: 16 consecutive beats, tags 0..15, out_ready = 1 -> first out_valid at cycle t+2, 16 contiguous outputs, tags in order.
- Backpressure: out_ready = 0 for 5 cycles mid-stream -> in_ready falls after the pipeline fills, no beat lost or duplicated, out_data stable while stalled.
- Reset: rst_n pulsed low with 2 beats in flight -> out_valid = 0 immediately (asynchronous), out_data = 0, no stale output after release.
- Random regression: NUM_COL=4 with REG_MID 0 and 1, random valid/ready, output compared against a reference model, and inv(fwd(x)) == x for every beat.
